// File: rtl/han_i2c_temp_target_pkg.sv
// Shared types and constants for the HAN I2C temperature target: FSM states,
// register indices and threshold reset values.
package han_i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    IGNORE
  } i2c_state_e;

  localparam logic [2:0] REG_FPGA_TEMP   = 3'd0;
  localparam logic [2:0] REG_BOARD_TEMP  = 3'd1;
  localparam logic [2:0] REG_FAN_RPM_HI  = 3'd2;
  localparam logic [2:0] REG_FAN_RPM_LO  = 3'd3;
  localparam logic [2:0] REG_ALARM       = 3'd4;
  localparam logic [2:0] REG_FAN_DAC     = 3'd5;
  localparam logic [2:0] REG_TEMP_SET_HI = 3'd6;
  localparam logic [2:0] REG_TEMP_SET_LO = 3'd7;

  localparam logic [7:0] TEMP_SET_HI_RST = 8'd37;
  localparam logic [7:0] TEMP_SET_LO_RST = 8'd32;

endpackage

// File: rtl/han_i2c_temp_target_if.sv
// I2C pad-side bus bundle: raw SCL/SDA inputs and the open-drain SDA pull-down.
interface han_i2c_temp_target_if;

  logic scl_in;
  logic sda_in;
  logic sda_oe;

  modport slave (
    input  scl_in,
    input  sda_in,
    output sda_oe
  );

  modport master (
    output scl_in,
    output sda_in,
    input  sda_oe
  );

endinterface

// File: rtl/han_i2c_temp_target_filter.sv
// Pad synchronizer plus glitch filter: a new level is accepted only after
// FILT_LEN consecutive equal synchronized samples; emits one-cycle edge pulses.
module han_i2c_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic [1:0]       sync_q;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Idle I2C lines are high, so everything resets to 1 to avoid a false edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], pin_i};
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_W'(FILT_LEN - 1)) begin
        level_d = sync_q[1];
        rise_d  = sync_q[1];
        fall_d  = ~sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/han_i2c_temp_target.sv
// I2C target exposing a pointer-addressed 8-register map of temperatures, fan
// status and two host-writable thresholds; shadows freeze while a host is active.
module han_i2c_temp_target
  import han_i2c_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR = 7'h4C,
  parameter int         FILT_LEN = 3
) (
  input  logic                     clk_50Mhz,
  input  logic                     reset_n,
  han_i2c_temp_target_if.slave     bus,
  input  logic [7:0]               fpga_temp_c,
  input  logic [7:0]               board_temp_c,
  input  logic [15:0]              fan_rpm,
  input  logic [7:0]               alarm_status,
  input  logic [7:0]               fan_dac,
  input  logic                     data_valid,
  output logic [7:0]               temp_set_hi,
  output logic [7:0]               temp_set_lo,
  output logic                     busy
);

  logic sclLevel, sclRise, sclFall;
  logic sdaLevel, sdaRise, sdaFall;
  logic startDet, stopDet;

  i2c_state_e state_q, state_d;
  logic [3:0] bitCnt_q, bitCnt_d;
  logic [7:0] rxShift_q, rxShift_d;
  logic [7:0] txShift_q, txShift_d;
  logic [2:0] pointer_q, pointer_d;
  logic       sdaOe_q, sdaOe_d;
  logic       busy_q, busy_d;
  logic       masterAck_q, masterAck_d;
  logic [7:0] tempSetHi_q, tempSetHi_d;
  logic [7:0] tempSetLo_q, tempSetLo_d;
  logic [7:0] shadow_q [6];
  logic [7:0] readByte;
  logic       byteDone;

  han_i2c_filter #(.FILT_LEN(FILT_LEN)) u_scl_filter (
    .clk_i   (clk_50Mhz),
    .rst_ni  (reset_n),
    .pin_i   (bus.scl_in),
    .level_o (sclLevel),
    .rise_o  (sclRise),
    .fall_o  (sclFall)
  );

  han_i2c_filter #(.FILT_LEN(FILT_LEN)) u_sda_filter (
    .clk_i   (clk_50Mhz),
    .rst_ni  (reset_n),
    .pin_i   (bus.sda_in),
    .level_o (sdaLevel),
    .rise_o  (sdaRise),
    .fall_o  (sdaFall)
  );

  assign startDet = sdaFall & sclLevel;
  assign stopDet  = sdaRise & sclLevel;
  assign byteDone = sclFall && (bitCnt_q == 4'd8);

  // Snapshots only refresh between transactions so multi-byte values stay coherent.
  always_ff @(posedge clk_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 6; i++) shadow_q[i] <= '0;
    end else if (data_valid && !busy_q) begin
      shadow_q[REG_FPGA_TEMP]  <= fpga_temp_c;
      shadow_q[REG_BOARD_TEMP] <= board_temp_c;
      shadow_q[REG_FAN_RPM_HI] <= fan_rpm[15:8];
      shadow_q[REG_FAN_RPM_LO] <= fan_rpm[7:0];
      shadow_q[REG_ALARM]      <= alarm_status;
      shadow_q[REG_FAN_DAC]    <= fan_dac;
    end
  end

  always_comb begin
    case (pointer_q)
      REG_FPGA_TEMP:   readByte = shadow_q[REG_FPGA_TEMP];
      REG_BOARD_TEMP:  readByte = shadow_q[REG_BOARD_TEMP];
      REG_FAN_RPM_HI:  readByte = shadow_q[REG_FAN_RPM_HI];
      REG_FAN_RPM_LO:  readByte = shadow_q[REG_FAN_RPM_LO];
      REG_ALARM:       readByte = shadow_q[REG_ALARM];
      REG_FAN_DAC:     readByte = shadow_q[REG_FAN_DAC];
      REG_TEMP_SET_HI: readByte = tempSetHi_q;
      default:         readByte = tempSetLo_q;
    endcase
  end

  always_ff @(posedge clk_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      bitCnt_q    <= '0;
      rxShift_q   <= '0;
      txShift_q   <= '0;
      pointer_q   <= '0;
      sdaOe_q     <= 1'b0;
      busy_q      <= 1'b0;
      masterAck_q <= 1'b0;
      tempSetHi_q <= TEMP_SET_HI_RST;
      tempSetLo_q <= TEMP_SET_LO_RST;
    end else begin
      state_q     <= state_d;
      bitCnt_q    <= bitCnt_d;
      rxShift_q   <= rxShift_d;
      txShift_q   <= txShift_d;
      pointer_q   <= pointer_d;
      sdaOe_q     <= sdaOe_d;
      busy_q      <= busy_d;
      masterAck_q <= masterAck_d;
      tempSetHi_q <= tempSetHi_d;
      tempSetLo_q <= tempSetLo_d;
    end
  end

  // sda_oe only moves in response to an SCL fall, so SDA never changes while SCL is high.
  always_comb begin
    state_d     = state_q;
    bitCnt_d    = bitCnt_q;
    rxShift_d   = rxShift_q;
    txShift_d   = txShift_q;
    pointer_d   = pointer_q;
    sdaOe_d     = sdaOe_q;
    busy_d      = busy_q;
    masterAck_d = masterAck_q;
    tempSetHi_d = tempSetHi_q;
    tempSetLo_d = tempSetLo_q;

    if (startDet) begin
      state_d  = ADDR;
      bitCnt_d = '0;
      sdaOe_d  = 1'b0;
      busy_d   = 1'b0;
    end else if (stopDet) begin
      state_d  = IDLE;
      bitCnt_d = '0;
      sdaOe_d  = 1'b0;
      busy_d   = 1'b0;
    end else begin
      if (sclRise && (state_q == ADDR || state_q == PTR || state_q == WDATA)) begin
        rxShift_d = {rxShift_q[6:0], sdaLevel};
        bitCnt_d  = bitCnt_q + 4'd1;
      end

      case (state_q)
        IDLE: sdaOe_d = 1'b0;

        ADDR: begin
          if (byteDone) begin
            bitCnt_d = '0;
            if (rxShift_q[7:1] == I2C_ADDR) begin
              state_d = ADDR_ACK;
              sdaOe_d = 1'b1;
              busy_d  = 1'b1;
            end else begin
              state_d = IGNORE;
            end
          end
        end

        ADDR_ACK: begin
          if (sclFall) begin
            bitCnt_d = '0;
            if (rxShift_q[0]) begin
              state_d   = RDATA;
              txShift_d = {readByte[6:0], 1'b0};
              sdaOe_d   = ~readByte[7];
            end else begin
              state_d = PTR;
              sdaOe_d = 1'b0;
            end
          end
        end

        PTR: begin
          if (byteDone) begin
            state_d   = PTR_ACK;
            bitCnt_d  = '0;
            sdaOe_d   = 1'b1;
            pointer_d = rxShift_q[2:0];
          end
        end

        PTR_ACK, WDATA_ACK: begin
          if (sclFall) begin
            state_d  = WDATA;
            bitCnt_d = '0;
            sdaOe_d  = 1'b0;
          end
        end

        WDATA: begin
          if (byteDone) begin
            state_d   = WDATA_ACK;
            bitCnt_d  = '0;
            sdaOe_d   = 1'b1;
            pointer_d = pointer_q + 3'd1;
            if (pointer_q == REG_TEMP_SET_HI) tempSetHi_d = rxShift_q;
            if (pointer_q == REG_TEMP_SET_LO) tempSetLo_d = rxShift_q;
          end
        end

        RDATA: begin
          if (sclRise) begin
            bitCnt_d = bitCnt_q + 4'd1;
          end else if (byteDone) begin
            state_d  = RDATA_ACK;
            bitCnt_d = '0;
            sdaOe_d  = 1'b0;
          end else if (sclFall) begin
            txShift_d = {txShift_q[6:0], 1'b0};
            sdaOe_d   = ~txShift_q[7];
          end
        end

        // The pointer advances on every completed read byte, acknowledged or not.
        RDATA_ACK: begin
          if (sclRise) begin
            masterAck_d = ~sdaLevel;
            pointer_d   = pointer_q + 3'd1;
          end else if (sclFall) begin
            bitCnt_d = '0;
            if (masterAck_q) begin
              state_d   = RDATA;
              txShift_d = {readByte[6:0], 1'b0};
              sdaOe_d   = ~readByte[7];
            end else begin
              state_d = IGNORE;
              sdaOe_d = 1'b0;
            end
          end
        end

        IGNORE: sdaOe_d = 1'b0;

        default: begin
          state_d = IDLE;
          sdaOe_d = 1'b0;
        end
      endcase
    end
  end

  assign bus.sda_oe  = sdaOe_q;
  assign busy        = busy_q;
  assign temp_set_hi = tempSetHi_q;
  assign temp_set_lo = tempSetLo_q;

endmodule

// File: tb/tb_han_i2c_temp_target.sv
// Directed bench for han_i2c_temp_target: a bit-banged I2C master on a wired-AND
// SDA line, with hand-computed expected register contents.
module tb_han_i2c_temp_target;

  localparam int Q = 10;

  logic        clk;
  logic        reset_n;
  logic        sclMaster;
  logic        sdaMaster;
  logic [7:0]  fpga_temp_c;
  logic [7:0]  board_temp_c;
  logic [15:0] fan_rpm;
  logic [7:0]  alarm_status;
  logic [7:0]  fan_dac;
  logic        data_valid;
  logic [7:0]  temp_set_hi;
  logic [7:0]  temp_set_lo;
  logic        busy;
  logic        glitchOn;
  logic        oeSeen;
  int          passCount;
  int          checkCount;

  han_i2c_temp_target_if bus ();

  assign bus.scl_in = sclMaster;
  assign bus.sda_in = sdaMaster & ~bus.sda_oe;

  han_i2c_temp_target #(.I2C_ADDR(7'h4C), .FILT_LEN(3)) dut (
    .clk_50Mhz    (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .fpga_temp_c  (fpga_temp_c),
    .board_temp_c (board_temp_c),
    .fan_rpm      (fan_rpm),
    .alarm_status (alarm_status),
    .fan_dac      (fan_dac),
    .data_valid   (data_valid),
    .temp_set_hi  (temp_set_hi),
    .temp_set_lo  (temp_set_lo),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(negedge clk) if (bus.sda_oe === 1'b1) oeSeen = 1'b1;

  task automatic waitQ();
    repeat (Q) @(negedge clk);
  endtask

  // One SCL period; an optional one-clock SCL spike is injected while SCL is low.
  task automatic clockBit(input logic b, output logic r);
    sdaMaster = b;
    if (glitchOn) begin
      repeat (4) @(negedge clk);
      sclMaster = 1'b1;
      @(negedge clk);
      sclMaster = 1'b0;
      repeat (Q - 5) @(negedge clk);
    end else begin
      waitQ();
    end
    sclMaster = 1'b1;
    waitQ();
    r = bus.sda_in;
    waitQ();
    sclMaster = 1'b0;
    waitQ();
  endtask

  task automatic startCond();
    sdaMaster = 1'b1;
    waitQ();
    sclMaster = 1'b1;
    waitQ();
    sdaMaster = 1'b0;
    waitQ();
    sclMaster = 1'b0;
    waitQ();
  endtask

  task automatic stopCond();
    sdaMaster = 1'b0;
    waitQ();
    sclMaster = 1'b1;
    waitQ();
    sdaMaster = 1'b1;
    waitQ();
  endtask

  task automatic writeByte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clockBit(d[i], r);
    clockBit(1'b1, r);
    ack = ~r;
  endtask

  task automatic readByte(input logic ackIt, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      clockBit(1'b1, r);
      d[i] = r;
    end
    clockBit(~ackIt, r);
  endtask

  task automatic pulseValid();
    @(negedge clk);
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  // Sets the pointer with a write, then a repeated START into a read.
  task automatic setPtrThenRead(input logic [7:0] ptr, input string tag);
    logic ack;
    startCond();
    writeByte(8'h98, ack);
    checkCount++;
    if (ack !== 1'b1) $display("[TB] FAIL %s addrW_ack: got %0b want 1", tag, ack); else passCount++;
    writeByte(ptr, ack);
    checkCount++;
    if (ack !== 1'b1) $display("[TB] FAIL %s ptr_ack: got %0b want 1", tag, ack); else passCount++;
    startCond();
    writeByte(8'h99, ack);
    checkCount++;
    if (ack !== 1'b1) $display("[TB] FAIL %s addrR_ack: got %0b want 1", tag, ack); else passCount++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (5) @(negedge clk);
    checkCount++;
    if (bus.sda_oe !== 1'b0) $display("[TB] FAIL rst_sda_oe: got %0b want 0", bus.sda_oe); else passCount++;
    checkCount++;
    if (busy !== 1'b0) $display("[TB] FAIL rst_busy: got %0b want 0", busy); else passCount++;
    checkCount++;
    if (temp_set_hi !== 8'd37) $display("[TB] FAIL rst_hi: got %0d want 37", temp_set_hi); else passCount++;
    checkCount++;
    if (temp_set_lo !== 8'd32) $display("[TB] FAIL rst_lo: got %0d want 32", temp_set_lo); else passCount++;
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_write_thresholds();
    logic ack;
    logic [7:0] bytes [4];
    bytes[0] = 8'h98; bytes[1] = 8'h06; bytes[2] = 8'h2A; bytes[3] = 8'h1E;
    startCond();
    for (int i = 0; i < 4; i++) begin
      writeByte(bytes[i], ack);
      checkCount++;
      if (ack !== 1'b1) $display("[TB] FAIL wr_ack%0d: got %0b want 1", i, ack); else passCount++;
      if (i == 0) begin
        checkCount++;
        if (busy !== 1'b1) $display("[TB] FAIL wr_busy: got %0b want 1", busy); else passCount++;
      end
    end
    stopCond();
    waitQ();
    checkCount++;
    if (temp_set_hi !== 8'h2A) $display("[TB] FAIL wr_hi: got %h want 2a", temp_set_hi); else passCount++;
    checkCount++;
    if (temp_set_lo !== 8'h1E) $display("[TB] FAIL wr_lo: got %h want 1e", temp_set_lo); else passCount++;
    checkCount++;
    if (busy !== 1'b0) $display("[TB] FAIL wr_busy_after_stop: got %0b want 0", busy); else passCount++;
  endtask

  task automatic test_shadow_read();
    logic ack;
    logic [7:0] d;
    fpga_temp_c = 8'd45; board_temp_c = 8'd30; fan_rpm = 16'h0BB8;
    alarm_status = 8'h05; fan_dac = 8'h80;
    pulseValid();
    setPtrThenRead(8'h02, "rpm");
    readByte(1'b1, d);
    checkCount++;
    if (d !== 8'h0B) $display("[TB] FAIL rpm_hi: got %h want 0b", d); else passCount++;
    readByte(1'b0, d);
    checkCount++;
    if (d !== 8'hB8) $display("[TB] FAIL rpm_lo: got %h want b8", d); else passCount++;
    stopCond();
    startCond();
    writeByte(8'h99, ack);
    checkCount++;
    if (ack !== 1'b1) $display("[TB] FAIL ptr4_ack: got %0b want 1", ack); else passCount++;
    readByte(1'b0, d);
    checkCount++;
    if (d !== 8'h05) $display("[TB] FAIL ptr4_alarm: got %h want 05", d); else passCount++;
    stopCond();
  endtask

  task automatic test_addr_mismatch();
    logic ack;
    logic [7:0] bytes [3];
    bytes[0] = 8'h9A; bytes[1] = 8'h06; bytes[2] = 8'h55;
    oeSeen = 1'b0;
    startCond();
    for (int i = 0; i < 3; i++) begin
      writeByte(bytes[i], ack);
      checkCount++;
      if (ack !== 1'b0) $display("[TB] FAIL nm_ack%0d: got %0b want 0", i, ack); else passCount++;
    end
    checkCount++;
    if (busy !== 1'b0) $display("[TB] FAIL nm_busy: got %0b want 0", busy); else passCount++;
    stopCond();
    checkCount++;
    if (oeSeen !== 1'b0) $display("[TB] FAIL nm_sda_oe: got %0b want 0", oeSeen); else passCount++;
    checkCount++;
    if (temp_set_hi !== 8'h2A) $display("[TB] FAIL nm_hi: got %h want 2a", temp_set_hi); else passCount++;
    checkCount++;
    if (temp_set_lo !== 8'h1E) $display("[TB] FAIL nm_lo: got %h want 1e", temp_set_lo); else passCount++;
  endtask

  task automatic test_wrap();
    logic [7:0] d;
    logic [7:0] want [3];
    want[0] = 8'h1E; want[1] = 8'd45; want[2] = 8'd30;
    setPtrThenRead(8'h07, "wrap");
    for (int i = 0; i < 3; i++) begin
      readByte(i < 2, d);
      checkCount++;
      if (d !== want[i]) $display("[TB] FAIL wrap_b%0d: got %h want %h", i, d, want[i]); else passCount++;
    end
    stopCond();
  endtask

  task automatic test_coherent();
    logic [7:0] d;
    setPtrThenRead(8'h01, "coh");
    readByte(1'b1, d);
    checkCount++;
    if (d !== 8'd30) $display("[TB] FAIL coh_b1: got %h want 1e", d); else passCount++;
    readByte(1'b1, d);
    checkCount++;
    if (d !== 8'h0B) $display("[TB] FAIL coh_b2: got %h want 0b", d); else passCount++;
    fan_rpm = 16'h1234;
    pulseValid();
    checkCount++;
    if (busy !== 1'b1) $display("[TB] FAIL coh_busy: got %0b want 1", busy); else passCount++;
    readByte(1'b0, d);
    checkCount++;
    if (d !== 8'hB8) $display("[TB] FAIL coh_b3: got %h want b8", d); else passCount++;
    stopCond();
    setPtrThenRead(8'h02, "coh_old");
    readByte(1'b1, d);
    checkCount++;
    if (d !== 8'h0B) $display("[TB] FAIL coh_old_hi: got %h want 0b", d); else passCount++;
    readByte(1'b0, d);
    checkCount++;
    if (d !== 8'hB8) $display("[TB] FAIL coh_old_lo: got %h want b8", d); else passCount++;
    stopCond();
    pulseValid();
    setPtrThenRead(8'h02, "coh_new");
    readByte(1'b1, d);
    checkCount++;
    if (d !== 8'h12) $display("[TB] FAIL coh_new_hi: got %h want 12", d); else passCount++;
    readByte(1'b0, d);
    checkCount++;
    if (d !== 8'h34) $display("[TB] FAIL coh_new_lo: got %h want 34", d); else passCount++;
    stopCond();
  endtask

  task automatic test_glitch_reset();
    logic ack;
    logic [7:0] d;
    glitchOn = 1'b1;
    startCond();
    writeByte(8'h98, ack);
    checkCount++;
    if (ack !== 1'b1) $display("[TB] FAIL gl_addr_ack: got %0b want 1", ack); else passCount++;
    writeByte(8'h06, ack);
    checkCount++;
    if (ack !== 1'b1) $display("[TB] FAIL gl_ptr_ack: got %0b want 1", ack); else passCount++;
    writeByte(8'h2B, ack);
    checkCount++;
    if (ack !== 1'b1) $display("[TB] FAIL gl_data_ack: got %0b want 1", ack); else passCount++;
    stopCond();
    setPtrThenRead(8'h06, "gl");
    readByte(1'b0, d);
    checkCount++;
    if (d !== 8'h2B) $display("[TB] FAIL gl_read: got %h want 2b", d); else passCount++;
    stopCond();
    glitchOn = 1'b0;

    // temp_set_lo = 0x1E has MSB 0, so the target is pulling SDA low at reset time.
    setPtrThenRead(8'h07, "rst");
    checkCount++;
    if (bus.sda_oe !== 1'b1) $display("[TB] FAIL rst_mid_drive: got %0b want 1", bus.sda_oe); else passCount++;
    sclMaster = 1'b1;
    waitQ();
    reset_n = 1'b0;
    #1;
    checkCount++;
    if (bus.sda_oe !== 1'b0) $display("[TB] FAIL rst_mid_release: got %0b want 0", bus.sda_oe); else passCount++;
    checkCount++;
    if (busy !== 1'b0) $display("[TB] FAIL rst_mid_busy: got %0b want 0", busy); else passCount++;
    checkCount++;
    if (temp_set_hi !== 8'd37 || temp_set_lo !== 8'd32)
      $display("[TB] FAIL rst_mid_thresh: got %0d/%0d want 37/32", temp_set_hi, temp_set_lo);
    else passCount++;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    sclMaster = 1'b0;
    waitQ();
    stopCond();

    setPtrThenRead(8'h06, "post");
    readByte(1'b1, d);
    checkCount++;
    if (d !== 8'd37) $display("[TB] FAIL post_hi: got %0d want 37", d); else passCount++;
    readByte(1'b1, d);
    checkCount++;
    if (d !== 8'd32) $display("[TB] FAIL post_lo: got %0d want 32", d); else passCount++;
    readByte(1'b0, d);
    checkCount++;
    if (d !== 8'd0) $display("[TB] FAIL post_shadow0: got %0d want 0", d); else passCount++;
    stopCond();
  endtask

  initial begin
    passCount    = 0;
    checkCount   = 0;
    glitchOn     = 1'b0;
    oeSeen       = 1'b0;
    sclMaster    = 1'b1;
    sdaMaster    = 1'b1;
    fpga_temp_c  = '0;
    board_temp_c = '0;
    fan_rpm      = '0;
    alarm_status = '0;
    fan_dac      = '0;
    data_valid   = 1'b0;
    reset_n      = 1'b0;

    test_reset();
    test_write_thresholds();
    test_shadow_read();
    test_addr_mismatch();
    test_wrap();
    test_coherent();
    test_glitch_reset();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
